// File: rtl/handshake_pkg.sv
// Shared types for the handshake source: operand pair layout and FSM state encoding.
package handshake_pkg;

  // Operand width used for both halves of a beat.
  localparam int OPERAND_W = 4;

  // One beat worth of data as stored in the FIFO and presented on the channel.
  typedef struct packed {
    logic [OPERAND_W-1:0] in1;
    logic [OPERAND_W-1:0] in2;
  } operand_t;

  // Transmit FSM: waiting for data, presenting a beat, or holding an idle bubble.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_SEND = 2'd1,
    HS_GAP  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/handshake_source_fifo.sv
// Synchronous FIFO of operand pairs with the head entry always visible on head_o.
// Pointers carry one extra wrap bit so full and empty are distinguishable by subtraction.
module handshake_source_fifo
  import handshake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             push_i,
  input  operand_t         push_data_i,
  input  logic             pop_i,
  output operand_t         head_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = LVL_W - 1;

  operand_t       mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           push_ok;
  logic           pop_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign push_ok = push_i && (level_o != LVL_W'(DEPTH));
  assign pop_ok  = pop_i && (level_o != '0);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write on accepted push.
  // NOTE: the data array has no reset; occupancy is tracked by the pointers alone,
  // and stale contents never reach the channel because outputs are gated by valid.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointer update; synchronous reset empties the FIFO.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/handshake_source.sv
// Ready/valid source for one handshake lane: buffers operand pairs, presents them one
// beat at a time with an optional bubble gap, and tracks accepted beats and stalls.
module handshake_source
  import handshake_pkg::*;
#(
  parameter int WIDTH   = OPERAND_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_in1,
  input  logic [WIDTH-1:0]       push_in2,
  input  logic [3:0]             gap_cycles,
  output logic                   handshake_valid,
  input  logic                   handshake_ready,
  output logic [WIDTH-1:0]       in1,
  output logic [WIDTH-1:0]       in2,
  output logic [CNT_W-1:0]       beat_count,
  output logic                   stall_timeout,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  hs_state_e          state_q, state_d;
  logic [3:0]         gap_q, gap_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   count_q, count_d;

  operand_t push_data;
  operand_t head;
  logic     push_acc;
  logic     pop;

  // push_ready depends only on registered occupancy, never on the downstream ready.
  assign push_ready      = (fifo_level != LVL_W'(DEPTH));
  assign push_acc        = push_valid && push_ready;
  assign handshake_valid = (state_q == HS_SEND);
  assign pop             = handshake_valid && handshake_ready;
  assign push_data       = '{in1: push_in1, in2: push_in2};

  // Data lines are held at zero whenever no beat is being presented.
  assign in1 = handshake_valid ? head.in1 : '0;
  assign in2 = handshake_valid ? head.in2 : '0;

  assign beat_count    = count_q;
  assign stall_timeout = timeout_q;

  handshake_source_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .push_i      (push_acc),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .level_o     (fifo_level)
  );

  // Next-state logic for the transmit FSM and bubble counter.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      HS_IDLE: begin
        if (fifo_level != '0) state_d = HS_SEND;
      end
      HS_SEND: begin
        if (handshake_ready) begin
          if (gap_cycles == 4'd0) begin
            // Continue only if an entry beyond the one leaving is already queued.
            state_d = (fifo_level > LVL_W'(1)) ? HS_SEND : HS_IDLE;
          end else begin
            gap_d   = gap_cycles;
            state_d = HS_GAP;
          end
        end
      end
      HS_GAP: begin
        if (gap_q == 4'd1) begin
          state_d = (fifo_level != '0) ? HS_SEND : HS_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // Stall watchdog (saturating) with sticky timeout flag, and the accepted-beat counter.
  always_comb begin
    stall_d = stall_q;
    if (pop) begin
      stall_d = '0;
    end else if (handshake_valid && (stall_q != STALL_W'(TIMEOUT))) begin
      stall_d = stall_q + STALL_W'(1);
    end
    timeout_d = timeout_q || (stall_d == STALL_W'(TIMEOUT));
    count_d   = pop ? count_q + CNT_W'(1) : count_q;
  end

  // State registers; reset drops any in-flight beat without counting it.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= HS_IDLE;
      gap_q     <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_handshake_source.sv
// Self-checking bench for handshake_source: reset, directed corner sequences, a
// cycle table for backpressure, and randomized traffic against a timing model.
module tb_handshake_source;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        push_valid;
  logic        push_ready;
  logic [3:0]  push_in1;
  logic [3:0]  push_in2;
  logic [3:0]  gap_cycles;
  logic        handshake_valid;
  logic        handshake_ready;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic [15:0] beat_count;
  logic        stall_timeout;
  logic [2:0]  fifo_level;

  always #5 CLK = ~CLK;

  handshake_source #(
    .WIDTH   (4),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_in1        (push_in1),
    .push_in2        (push_in2),
    .gap_cycles      (gap_cycles),
    .handshake_valid (handshake_valid),
    .handshake_ready (handshake_ready),
    .in1             (in1),
    .in2             (in2),
    .beat_count      (beat_count),
    .stall_timeout   (stall_timeout),
    .fifo_level      (fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] g, input logic rdy);
    push_valid      = pv;
    push_in1        = a;
    push_in2        = b;
    gap_cycles      = g;
    handshake_ready = rdy;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    advance();
    advance();
    RESETN = 1'b1;
  endtask

  typedef struct {
    logic        pv;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_in1;
    logic [3:0]  exp_in2;
    logic [2:0]  exp_level;
    logic        exp_pr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  // Timing model state for the randomized phase.
  logic [7:0] mq [$];
  bit         m_present;
  int         m_check_at;
  int         m_stall;
  bit         m_sticky;
  int         m_cnt;

  initial begin
    logic [4:0] gap_pat;
    bit         exp_v;
    bit         pv_r;
    bit         rdy_r;
    logic [3:0] a_r, b_r, g_r;
    int         lvl_before;
    bit         accept;

    // Backpressure: fill to DEPTH with ready low, refuse a fifth push, then drain.
    tbl[0] = '{1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 4'h3, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 3'd1, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 4'h5, 4'h6, 1'b0, 1'b1, 4'h1, 4'h2, 3'd2, 1'b1, 16'd0};
    tbl[3] = '{1'b1, 4'h7, 4'h8, 1'b0, 1'b1, 4'h1, 4'h2, 3'd3, 1'b1, 16'd0};
    tbl[4] = '{1'b1, 4'h9, 4'hA, 1'b0, 1'b1, 4'h1, 4'h2, 3'd4, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h2, 3'd4, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h3, 4'h4, 3'd3, 1'b1, 16'd1};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h5, 4'h6, 3'd2, 1'b1, 16'd2};
    tbl[8] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h7, 4'h8, 3'd1, 1'b1, 16'd3};
    tbl[9] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 16'd4};

    // Reset held three cycles with push_valid asserted.
    RESETN = 1'b0;
    drive(1'b1, 4'h5, 4'h6, 4'h0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_valid", handshake_valid, 0);
      check("rst_push_ready", push_ready, 1);
      check("rst_level", fifo_level, 0);
      check("rst_count", beat_count, 0);
      check("rst_timeout", stall_timeout, 0);
      advance();
    end

    // Backpressure table.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pv, tbl[i].a, tbl[i].b, 4'h0, tbl[i].rdy);
      sample();
      check($sformatf("bp%0d_valid", i), handshake_valid, tbl[i].exp_valid);
      check($sformatf("bp%0d_in1", i), in1, tbl[i].exp_in1);
      check($sformatf("bp%0d_in2", i), in2, tbl[i].exp_in2);
      check($sformatf("bp%0d_level", i), fifo_level, tbl[i].exp_level);
      check($sformatf("bp%0d_push_ready", i), push_ready, tbl[i].exp_pr);
      check($sformatf("bp%0d_count", i), beat_count, tbl[i].exp_cnt);
      advance();
    end

    // Single beat: valid appears two cycles after the push.
    do_reset();
    drive(1'b1, 4'hF, 4'h3, 4'h0, 1'b1);
    sample();
    check("single_c0_valid", handshake_valid, 0);
    advance();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    sample();
    check("single_c1_valid", handshake_valid, 0);
    advance();
    sample();
    check("single_c2_valid", handshake_valid, 1);
    check("single_c2_in1", in1, 4'hF);
    check("single_c2_in2", in2, 4'h3);
    advance();
    sample();
    check("single_c3_valid", handshake_valid, 0);
    check("single_c3_count", beat_count, 1);
    check("single_c3_level", fifo_level, 0);
    advance();

    // Gap of three: valid high one cycle, low three, high again.
    do_reset();
    drive(1'b1, 4'h1, 4'h1, 4'd3, 1'b1);
    advance();
    drive(1'b1, 4'h2, 4'h2, 4'd3, 1'b1);
    advance();
    gap_pat = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'h0, 4'h0, 4'd3, 1'b1);
      sample();
      check($sformatf("gap_k%0d_valid", k), handshake_valid, gap_pat[k]);
      if (k == 0) check("gap_first_in1", in1, 4'h1);
      if (k == 4) check("gap_second_in1", in1, 4'h2);
      advance();
    end

    // Watchdog: sixteen stall cycles set the sticky flag, which survives the accept.
    do_reset();
    drive(1'b1, 4'hA, 4'hB, 4'h0, 1'b0);
    advance();
    for (int c = 1; c <= 17; c++) begin
      drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
      sample();
      if (c == 2)  check("wd_first_stall_valid", handshake_valid, 1);
      if (c == 17) check("wd_before_timeout", stall_timeout, 0);
      advance();
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    sample();
    check("wd_timeout_set", stall_timeout, 1);
    check("wd_still_valid", handshake_valid, 1);
    check("wd_data_stable", in1, 4'hA);
    advance();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    sample();
    check("wd_timeout_sticky", stall_timeout, 1);
    check("wd_count", beat_count, 1);
    advance();

    // Reset in the middle of a stalled beat drops it.
    do_reset();
    drive(1'b1, 4'hC, 4'hD, 4'h0, 1'b0);
    advance();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    advance();
    sample();
    check("mid_valid_before", handshake_valid, 1);
    check("mid_in1_before", in1, 4'hC);
    advance();
    RESETN = 1'b0;
    advance();
    RESETN = 1'b1;
    sample();
    check("mid_valid_after", handshake_valid, 0);
    check("mid_level_after", fifo_level, 0);
    check("mid_count_after", beat_count, 0);
    check("mid_in1_after", in1, 0);
    advance();
    sample();
    check("mid_valid_later", handshake_valid, 0);
    advance();

    // Randomized traffic against a timestamp-based model of the channel.
    do_reset();
    mq.delete();
    m_present  = 0;
    m_check_at = 0;
    m_stall    = 0;
    m_sticky   = 0;
    m_cnt      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pv_r  = ($urandom_range(0, 1) == 1);
      a_r   = 4'($urandom_range(0, 15));
      b_r   = 4'($urandom_range(0, 15));
      g_r   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
      rdy_r = ($urandom_range(0, 9) < 6);
      if (cyc >= 1500 && cyc < 1540) rdy_r = 1'b0;
      drive(pv_r, a_r, b_r, g_r, rdy_r);
      sample();

      exp_v = m_present;
      check("rnd_valid", handshake_valid, exp_v);
      check("rnd_in1", in1, exp_v ? mq[0][7:4] : 4'h0);
      check("rnd_in2", in2, exp_v ? mq[0][3:0] : 4'h0);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_push_ready", push_ready, mq.size() != DEPTH);
      check("rnd_count", beat_count, m_cnt & 16'hFFFF);
      check("rnd_timeout", stall_timeout, m_sticky);

      lvl_before = mq.size();
      accept     = m_present && rdy_r;
      if (accept) begin
        m_cnt++;
        m_stall = 0;
        if (g_r == 0) begin
          if (lvl_before > 1) begin
            m_present = 1;
          end else begin
            m_present  = 0;
            m_check_at = cyc + 1;
          end
        end else begin
          m_present  = 0;
          m_check_at = cyc + int'(g_r);
        end
      end else if (m_present) begin
        if (m_stall < TIMEOUT) m_stall++;
        if (m_stall >= TIMEOUT) m_sticky = 1;
      end else begin
        m_present = (cyc >= m_check_at) && (lvl_before != 0);
      end
      if (accept) void'(mq.pop_front());
      if (pv_r && (lvl_before != DEPTH)) mq.push_back({a_r, b_r});
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
